// File: rtl/spi_bitrev_slave.sv
// SPI slave that receives one WIDTH-bit word and then answers with the same word bit-reversed.
// Optional frame counter enabled by defining SPI_BITREV_FRAME_CNT_EN.
module spi_bitrev_slave #(
    parameter int WIDTH = 8,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             busy,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             abort,
    output logic [15:0]      frame_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RX, TX, HOLD} state_t;

    state_t           state, state_next;
    logic [2:0]       sck_sync;
    logic [2:0]       ss_sync;
    logic [1:0]       mosi_sync;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;

    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, drive_edge, ss_high, ss_fall, last_bit;
    logic start, shift_in, rx_done, tx_sample, tx_shift, tx_done, go_abort;

    // Two synchroniser stages plus one history stage for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= {3{CPOL}};
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck};
            ss_sync   <= {ss_sync[1:0], ss};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_high     = ss_sync[1];
    assign ss_fall     = ~ss_sync[1] & ss_sync[2];
    assign last_bit    = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_in   = 1'b0;
        rx_done    = 1'b0;
        tx_sample  = 1'b0;
        tx_shift   = 1'b0;
        tx_done    = 1'b0;
        go_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = RX;
                    start      = 1'b1;
                end
            end
            RX: begin
                // A deselect wins over any sck edge seen in the same cycle.
                if (ss_high) begin
                    state_next = IDLE;
                    go_abort   = 1'b1;
                end else if (sample_edge) begin
                    shift_in = 1'b1;
                    if (last_bit) begin
                        state_next = TX;
                        rx_done    = 1'b1;
                    end
                end
            end
            TX: begin
                if (ss_high) begin
                    state_next = IDLE;
                    go_abort   = 1'b1;
                end else begin
                    tx_shift = drive_edge;
                    if (sample_edge) begin
                        tx_sample = 1'b1;
                        if (last_bit) begin
                            state_next = HOLD;
                            tx_done    = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (ss_high) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            miso     <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            abort    <= 1'b0;
        end else begin
            rx_valid <= rx_done;
            abort    <= go_abort;

            if (start || go_abort || rx_done || tx_done)
                bit_cnt <= '0;
            else if (shift_in || tx_sample)
                bit_cnt <= bit_cnt + CW'(1);

            // The received word is shifted out LSB first, which is the bit reversal.
            if (start)
                shreg <= '0;
            else if (shift_in)
                shreg <= {shreg[WIDTH-2:0], mosi_sync[1]};
            else if (tx_shift)
                shreg <= shreg >> 1;

            if (rx_done)
                rx_data <= {shreg[WIDTH-2:0], mosi_sync[1]};

            if (tx_shift)
                miso <= shreg[0];
            else if (state_next != TX)
                miso <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

`ifdef SPI_BITREV_FRAME_CNT_EN
    logic [15:0] frame_count;

    always_ff @(posedge clock) begin
        if (reset)        frame_count <= '0;
        else if (tx_done) frame_count <= frame_count + 16'd1;
    end

    assign frame_cnt = frame_count;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: doc/spi_bitrev_slave.md
SPI_BITREV_SLAVE -- requirements
Module: spi_bitrev_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits (range 2..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sck  input  1  SPI serial clock, asynchronous to clock.
REQ-007 SHALL have port ss  input  1  slave select, active low, asynchronous.
REQ-008 SHALL have port mosi  input  1  master-out data, MSB first.
REQ-009 SHALL have port miso  output  1  slave-out data; 1 whenever not transmitting.
REQ-010 SHALL have port busy  output  1  high in RX, TX or HOLD state.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse when a full word is received.
REQ-012 SHALL have port rx_data  output  WIDTH  last received word, held until the next rx_valid.
REQ-013 SHALL have port abort  output  1  one-cycle pulse when ss deasserts mid-frame.
REQ-014 SHALL have port frame_cnt  output  16  count of completed frames (see Configuration).

Function
REQ-015 SHALL pass sck, ss and mosi through 2-flop synchronisers, then detect sck edges from synchronised history; a requirement on the user is clock >= 8x sck frequency.
REQ-016 SHALL define leading edge = rising if CPOL=0, falling if CPOL=1; sample edge = leading if CPHA=0, else trailing; drive edge = the other edge.
REQ-017 SHALL implement states IDLE, RX, TX, HOLD.
REQ-018 IDLE: miso=1; synchronised ss falling -> RX with bit counter 0 and shift register 0.
REQ-019 RX: each sample edge shifts mosi into the register LSB (MSB-first word); on the WIDTH-th sample edge -> TX, and rx_valid pulses on the following cycle with rx_data = received word.
REQ-020 TX: on each drive edge miso SHALL output the next bit of the bit-reversed word, i.e. rx word bit 0 first, bit WIDTH-1 last; the WIDTH-th sample edge in TX -> HOLD.
REQ-021 HOLD: miso=1; further sck edges are ignored; ss deassert -> IDLE with no abort.
REQ-022 Synchronised ss high in RX or TX SHALL force IDLE, miso=1, counter 0, and one abort pulse; rx_valid SHALL NOT fire for the partial word.
REQ-023 ss deassert and a sample edge detected in the same cycle: ss wins, and the edge is discarded.
REQ-024 Response latency SHALL be 3 clock cycles from a pin-level sck edge to a miso change (2 sync + 1 register).
REQ-025 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and reset to 0 on every RX->TX transition.
REQ-026 busy SHALL be combinational from state: 0 in IDLE, else 1.

Reset
REQ-027 reset SHALL force state IDLE, miso=1, rx_valid=0, abort=0, rx_data=0, frame_cnt=0, counter=0, and synchroniser flops to ss=1 and sck=CPOL.
REQ-028 reset asserted mid-frame SHALL abandon the frame with no abort pulse; after release, a new frame starts only on a fresh ss falling edge.

Configuration
REQ-029 With macro SPI_BITREV_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 on each TX->HOLD transition, wrap 0xFFFF->0x0000, and not change on abort.
REQ-030 Without SPI_BITREV_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-031 WIDTH=8, CPOL=0, CPHA=0: send 0xB2 -> rx_valid once, rx_data=0xB2; the following 8 clocks return 0x4D on miso, MSB-first as sampled.
REQ-032 WIDTH=8, CPOL=1, CPHA=1: send 0x01 -> rx_data=0x01; master reads 0x80.
REQ-033 WIDTH=16, mode 0: send 0x1234 -> rx_data=0x1234; master reads 0x2C48.
REQ-034 Raise ss after 5 RX bits -> abort pulses once, no rx_valid, miso=1; the next full 0xB2 frame -> 0x4D correct.
REQ-035 Assert reset during TX bit 3 -> miso=1 and busy=0 the cycle after reset; a new frame completes normally.
REQ-036 SPI_BITREV_FRAME_CNT_EN defined, frame_cnt preloaded via forcing to 0xFFFF, one frame -> 0x0000; without the macro, frame_cnt stays 0 throughout.
